// File: rtl/chip8_pkg.sv
// chip8_pkg: shared widths, requester IDs and arbiter state encoding
package chip8_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {REQ_NONE = 2'd0, REQ_CPU = 2'd1, REQ_GPU = 2'd2, REQ_LD = 2'd3} req_id_e;
  typedef enum logic {OPEN = 1'b0, LOCKED = 1'b1} arb_state_e;
endpackage

// File: rtl/chip8_rr2.sv
// chip8_rr2: two-way cpu/gpu round-robin picker holding last_gpu
module chip8_rr2 (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic gpu_req,
  input  logic grant_cpu,
  input  logic grant_gpu,
  input  logic force_gpu,
  output logic pick_cpu,
  output logic pick_gpu
);
  logic last_gpu_q, last_gpu_d;
  always_comb begin
    pick_cpu   = cpu_req & (last_gpu_q | ~gpu_req);
    pick_gpu   = gpu_req & ~pick_cpu;
    last_gpu_d = (force_gpu | grant_gpu) ? 1'b1 : grant_cpu ? 1'b0 : last_gpu_q;
  end
  always_ff @(posedge clk) begin
    if (reset) last_gpu_q <= 1'b1;
    else last_gpu_q <= last_gpu_d;
  end
endmodule

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: shares the single-port CHIP-8 memory between cpu, gpu and loader
module chip8_mem_arbiter #(
  parameter int ADDR_W   = chip8_pkg::ADDR_W,
  parameter int DATA_W   = chip8_pkg::DATA_W,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  input  logic              gpu_req,
  input  logic              gpu_we,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wdata,
  input  logic              gpu_lock,
  output logic              gpu_ack,
  output logic              gpu_rvalid,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import chip8_pkg::*;
  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  arb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_id_e grant, sel, sel_q, sel_d, rd_id_q, rd_id_d;
  logic force_rel, pick_cpu, pick_gpu, sel_we;
  chip8_rr2 u_rr2 (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .gpu_req   (gpu_req),
    .grant_cpu (grant == REQ_CPU),
    .grant_gpu (grant == REQ_GPU),
    .force_gpu (force_rel),
    .pick_cpu  (pick_cpu),
    .pick_gpu  (pick_gpu)
  );
  always_comb begin
    grant     = REQ_NONE;
    state_d   = state_q;
    cnt_d     = cnt_q;
    force_rel = 1'b0;
    if (!reset && state_q == OPEN) begin
      grant = ld_req ? REQ_LD : pick_cpu ? REQ_CPU : pick_gpu ? REQ_GPU : REQ_NONE;
      if (grant == REQ_GPU && gpu_lock) begin
        state_d = LOCKED;
        cnt_d   = '0;
      end
    end else if (!reset) begin
      grant     = gpu_req ? REQ_GPU : REQ_NONE;
      cnt_d     = cnt_q + 1'b1;
      force_rel = cnt_d == CNT_W'(LOCK_MAX - 1);
      state_d   = (!gpu_lock || force_rel) ? OPEN : LOCKED;
    end
    // idle cycles keep the last granted requester on the memory bus
    sel        = (grant == REQ_NONE) ? sel_q : grant;
    sel_d      = sel;
    mem_addr   = (sel == REQ_LD) ? ld_addr : (sel == REQ_GPU) ? gpu_addr : cpu_addr;
    mem_wdata  = (sel == REQ_LD) ? ld_wdata : (sel == REQ_GPU) ? gpu_wdata : cpu_wdata;
    sel_we     = (sel == REQ_LD) ? ld_we : (sel == REQ_GPU) ? gpu_we : cpu_we;
    mem_we     = (grant != REQ_NONE) && sel_we;
    rd_id_d    = (grant != REQ_NONE && !sel_we) ? grant : REQ_NONE;
    cpu_ack    = grant == REQ_CPU;
    gpu_ack    = grant == REQ_GPU;
    ld_ack     = grant == REQ_LD;
    cpu_rvalid = rd_id_q == REQ_CPU;
    gpu_rvalid = rd_id_q == REQ_GPU;
    ld_rvalid  = rd_id_q == REQ_LD;
    rdata      = mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OPEN;
      cnt_q   <= '0;
      sel_q   <= REQ_CPU;
      rd_id_q <= REQ_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rd_id_q <= rd_id_d;
    end
  end
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: random requesters checked against a behavioural arbitration model
module tb_chip8_mem_arbiter;
  localparam int LOCK_MAX = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  bit rq[3], rw[3], lock_in, rst_in;
  logic [11:0] ra[3];
  logic [7:0] rd[3];
  logic cpu_ack, cpu_rvalid, gpu_ack, gpu_rvalid, ld_ack, ld_rvalid, mem_we;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;
  logic [7:0] mem [4096];
  logic [7:0] ref_mem [4096];
  bit locked, last_gpu;
  int budget, pend_id, n_checks, n_errors, run, lock_checks;
  logic [7:0] pend_data;
  logic [2:0] last_acks;
  chip8_mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(rst_in),
    .cpu_req(rq[0]), .cpu_we(rw[0]), .cpu_addr(ra[0]), .cpu_wdata(rd[0]), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
    .gpu_req(rq[1]), .gpu_we(rw[1]), .gpu_addr(ra[1]), .gpu_wdata(rd[1]), .gpu_lock(lock_in), .gpu_ack(gpu_ack), .gpu_rvalid(gpu_rvalid),
    .ld_req(rq[2]), .ld_we(rw[2]), .ld_addr(ra[2]), .ld_wdata(rd[2]), .ld_ack(ld_ack), .ld_rvalid(ld_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(bit rnd, int p_req, int p_lock, int p_rst, int p_drop);
    int g;
    bit we_exp;
    if (rnd) begin
      for (int k = 0; k < 3; k++) begin
        if (rq[k] && $urandom_range(99) < p_drop) rq[k] = 1'b0;
        else if (!rq[k]) begin
          rq[k] = $urandom_range(99) < p_req;
          rw[k] = $urandom_range(1) == 1;
          ra[k] = $urandom_range(1) == 1 ? 12'($urandom_range(31)) : 12'($urandom);
          rd[k] = 8'($urandom);
        end
      end
      lock_in = $urandom_range(99) < p_lock;
      rst_in  = $urandom_range(99) < p_rst;
    end
    @(negedge clk);
    #1;
    g = 0;
    if (!rst_in) begin
      if (locked) g = rq[1] ? 2 : 0;
      else if (rq[2]) g = 3;
      else if (rq[0] && rq[1]) g = last_gpu ? 1 : 2;
      else if (rq[0]) g = 1;
      else if (rq[1]) g = 2;
    end
    last_acks = {ld_ack, gpu_ack, cpu_ack};
    check("acks", 32'(last_acks), (g != 0) ? (1 << (g - 1)) : 0);
    we_exp = 1'b0;
    if (g != 0) begin
      we_exp = rw[g-1];
      check("mem_addr", 32'(mem_addr), 32'(ra[g-1]));
      if (we_exp) check("mem_wdata", 32'(mem_wdata), 32'(rd[g-1]));
    end
    check("mem_we", 32'(mem_we), 32'(we_exp));
    check("rvalid", 32'({ld_rvalid, gpu_rvalid, cpu_rvalid}), (pend_id != 0) ? (1 << (pend_id - 1)) : 0);
    if (pend_id != 0) check("rdata", 32'(rdata), 32'(pend_data));
    pend_id = 0;
    if (g != 0) begin
      if (we_exp) ref_mem[ra[g-1]] = rd[g-1];
      else begin
        pend_id   = g;
        pend_data = ref_mem[ra[g-1]];
      end
    end
    if (rst_in) begin
      locked = 1'b0;
      last_gpu = 1'b1;
      budget = 0;
    end else if (locked) begin
      if (g == 2) last_gpu = 1'b1;
      budget--;
      if (budget == 0) begin
        locked = 1'b0;
        last_gpu = 1'b1;
      end else if (!lock_in) locked = 1'b0;
    end else begin
      if (g == 1) last_gpu = 1'b0;
      if (g == 2) begin
        last_gpu = 1'b1;
        if (lock_in) begin
          locked = 1'b1;
          budget = LOCK_MAX - 1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (g != 0) rq[g-1] = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[12'h200] = 8'h12;
    ref_mem[12'h200] = 8'h12;
    last_gpu = 1'b1;
    rst_in = 1'b1;
    repeat (2) step(1'b0, 0, 0, 0, 0);
    rst_in = 1'b0;
    rq[0] = 1'b1;
    rw[0] = 1'b0;
    ra[0] = 12'h200;
    step(1'b0, 0, 0, 0, 0);
    check("first_cpu_ack", 32'(last_acks), 32'd1);
    step(1'b0, 0, 0, 0, 0);
    repeat (3000) step(1'b1, 60, 70, 2, 5);
    rst_in = 1'b1;
    step(1'b0, 0, 0, 0, 0);
    rst_in = 1'b0;
    run = 0;
    repeat (40) begin
      rq = '{1'b1, 1'b1, 1'b0};
      rw = '{1'b0, 1'b0, 1'b0};
      ra[0] = 12'h201;
      ra[1] = 12'h300;
      lock_in = 1'b1;
      step(1'b0, 0, 0, 0, 0);
      if (last_acks == 3'b010) run++;
      else if (last_acks == 3'b001 && run > 0) begin
        check("lock_run", 32'(run), 32'(LOCK_MAX));
        lock_checks++;
        run = 0;
      end
    end
    check("lock_runs_seen", 32'(lock_checks), 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
